// File: rtl/fifo_param_flags_if.sv
// Producer/consumer bus of the parametrised FIFO.
// Controls and status flags are active-low.
interface fifo_param_flags_if #(
  parameter int FWIDTH  = 32,
  parameter int FCWIDTH = 4
);
  logic [FWIDTH-1:0]  Data_In;
  logic               FInN;
  logic               FOutN;
  logic               FClrN;
  logic [FCWIDTH:0]   AFullThr;
  logic [FCWIDTH:0]   AEmptyThr;
  logic [FWIDTH-1:0]  F_Data;
  logic [FCWIDTH:0]   F_Count;
  logic               F_FullN;
  logic               F_EmptyN;
  logic               F_AFullN;
  logic               F_AEmptyN;
  logic               F_OvfN;
  logic               F_UdfN;

  modport master (
    output Data_In, FInN, FOutN, FClrN, AFullThr, AEmptyThr,
    input  F_Data, F_Count, F_FullN, F_EmptyN, F_AFullN, F_AEmptyN, F_OvfN, F_UdfN
  );

  modport slave (
    input  Data_In, FInN, FOutN, FClrN, AFullThr, AEmptyThr,
    output F_Data, F_Count, F_FullN, F_EmptyN, F_AFullN, F_AEmptyN, F_OvfN, F_UdfN
  );
endinterface

// File: rtl/fifo_param_flags.sv
// Parametrised single-clock show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_param_flags #(
  parameter int FWIDTH  = 32,
  parameter int FDEPTH  = 16,
  parameter int FCWIDTH = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  fifo_param_flags_if.slave  fifoBus
);

  localparam logic [FCWIDTH:0]   DEPTH_C   = (FCWIDTH+1)'(FDEPTH);
  localparam logic [FCWIDTH:0]   CNT_ZERO_C = {(FCWIDTH+1){1'b0}};
  localparam logic [FCWIDTH:0]   CNT_ONE_C  = {{FCWIDTH{1'b0}}, 1'b1};
  localparam logic [FCWIDTH-1:0] PTR_ZERO_C = {FCWIDTH{1'b0}};
  localparam logic [FCWIDTH-1:0] PTR_ONE_C  = {{(FCWIDTH-1){1'b0}}, 1'b1};

  logic [FWIDTH-1:0]  memR [FDEPTH];
  logic [FCWIDTH-1:0] rdPtrR;
  logic [FCWIDTH-1:0] wrPtrR;
  logic [FCWIDTH:0]   countR;
  logic [FCWIDTH:0]   countNextS;
  logic               fullNR;
  logic               emptyNR;
  logic               aFullNR;
  logic               aEmptyNR;
  logic               ovfNR;
  logic               udfNR;
  logic               rdAccS;
  logic               wrAccS;
  logic               flushS;
  logic               memWrS;

  // Accept decisions and next occupancy; a read frees a slot for a same-cycle write.
  always_comb begin
    flushS     = Rst || !fifoBus.FClrN;
    rdAccS     = !fifoBus.FOutN && (countR != CNT_ZERO_C);
    wrAccS     = !fifoBus.FInN && ((countR != DEPTH_C) || rdAccS);
    memWrS     = wrAccS && !flushS;
    countNextS = countR;
    case ({wrAccS, rdAccS})
      2'b10:   countNextS = countR + CNT_ONE_C;
      2'b01:   countNextS = countR - CNT_ONE_C;
      default: countNextS = countR;
    endcase
  end

  // Pointers, count and flags; flags derive from the next count so they never lag it.
  always_ff @(posedge Clk) begin
    if (flushS) begin
      rdPtrR   <= PTR_ZERO_C;
      wrPtrR   <= PTR_ZERO_C;
      countR   <= CNT_ZERO_C;
      fullNR   <= 1'b1;
      emptyNR  <= 1'b0;
      aFullNR  <= 1'b1;
      aEmptyNR <= 1'b0;
      ovfNR    <= 1'b1;
      udfNR    <= 1'b1;
    end else begin
      if (wrAccS) begin
        wrPtrR <= wrPtrR + PTR_ONE_C;
      end
      if (rdAccS) begin
        rdPtrR <= rdPtrR + PTR_ONE_C;
      end
      countR   <= countNextS;
      fullNR   <= (countNextS != DEPTH_C);
      emptyNR  <= (countNextS != CNT_ZERO_C);
      aFullNR  <= !(countNextS >= fifoBus.AFullThr);
      aEmptyNR <= !(countNextS <= fifoBus.AEmptyThr);
      if (!fifoBus.FInN && !wrAccS) begin
        ovfNR <= 1'b0;
      end
      if (!fifoBus.FOutN && !rdAccS) begin
        udfNR <= 1'b0;
      end
    end
  end

  // Storage array; contents survive reset and clear on purpose.
  always_ff @(posedge Clk) begin
    if (memWrS) begin
      memR[wrPtrR] <= fifoBus.Data_In;
    end
  end

  assign fifoBus.F_Data    = memR[rdPtrR];
  assign fifoBus.F_Count   = countR;
  assign fifoBus.F_FullN   = fullNR;
  assign fifoBus.F_EmptyN  = emptyNR;
  assign fifoBus.F_AFullN  = aFullNR;
  assign fifoBus.F_AEmptyN = aEmptyNR;
  assign fifoBus.F_OvfN    = ovfNR;
  assign fifoBus.F_UdfN    = udfNR;

endmodule

// File: tb/tb_fifo_param_flags.sv
// Directed bench for fifo_param_flags: a queue model checked every cycle plus
// hand-computed literal expectations.
module tb_fifo_param_flags;

  localparam int W = 32;
  localparam int D = 16;
  localparam int C = 4;

  logic Clk;
  logic Rst;
  int   tests;
  int   fails;

  logic [W-1:0] mq[$];
  logic         mOvfN;
  logic         mUdfN;
  logic [C:0]   mAf;
  logic [C:0]   mAe;

  fifo_param_flags_if #(.FWIDTH(W), .FCWIDTH(C)) bus ();

  fifo_param_flags #(.FWIDTH(W), .FDEPTH(D), .FCWIDTH(C)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .fifoBus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    int sz;
    sz = mq.size();
    chk("count",   W'(bus.F_Count),   W'(sz));
    chk("fullN",   W'(bus.F_FullN),   W'(sz != D));
    chk("emptyN",  W'(bus.F_EmptyN),  W'(sz != 0));
    chk("afullN",  W'(bus.F_AFullN),  W'(!(sz >= int'(mAf))));
    chk("aemptyN", W'(bus.F_AEmptyN), W'(!(sz <= int'(mAe))));
    chk("ovfN",    W'(bus.F_OvfN),    W'(mOvfN));
    chk("udfN",    W'(bus.F_UdfN),    W'(mUdfN));
    if (sz > 0) begin
      chk("data", bus.F_Data, mq[0]);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare at negedge.
  task automatic step(input logic rst, input logic clrN, input logic finN,
                      input logic foutN, input logic [W-1:0] din);
    bit rd;
    bit wr;
    Rst           = rst;
    bus.FClrN     = clrN;
    bus.FInN      = finN;
    bus.FOutN     = foutN;
    bus.Data_In   = din;
    @(posedge Clk);
    mAf = bus.AFullThr;
    mAe = bus.AEmptyThr;
    if (rst || !clrN) begin
      mq.delete();
      mOvfN = 1'b1;
      mUdfN = 1'b1;
    end else begin
      rd = !foutN && (mq.size() != 0);
      wr = !finN && ((mq.size() != D) || rd);
      if (!finN && !wr) mOvfN = 1'b0;
      if (!foutN && !rd) mUdfN = 1'b0;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(din);
    end
    @(negedge Clk);
    compareAll();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mOvfN = 1'b1;
    mUdfN = 1'b1;
    bus.AFullThr  = 5'd14;
    bus.AEmptyThr = 5'd2;
    @(negedge Clk);

    // Reset state
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("rst_count",  W'(bus.F_Count),   32'd0);
    chk("rst_emptyN", W'(bus.F_EmptyN),  32'd0);
    chk("rst_fullN",  W'(bus.F_FullN),   32'd1);
    chk("rst_aemN",   W'(bus.F_AEmptyN), 32'd0);
    chk("rst_afuN",   W'(bus.F_AFullN),  32'd1);
    chk("rst_ovfN",   W'(bus.F_OvfN),    32'd1);
    chk("rst_udfN",   W'(bus.F_UdfN),    32'd1);

    // Fill to full, then drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(i));
      chk("fill_count", W'(bus.F_Count), 32'(i + 1));
      if (i == 0) chk("fill_emptyN", W'(bus.F_EmptyN), 32'd1);
    end
    chk("full_fullN", W'(bus.F_FullN), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", bus.F_Data, 32'h100 + 32'(i));
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("drain_emptyN", W'(bus.F_EmptyN), 32'd0);

    // Overflow on full, then write+read when full
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200 + 32'(i));
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD);
    chk("ovf_flag",  W'(bus.F_OvfN),  32'd0);
    chk("ovf_count", W'(bus.F_Count), 32'd16);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hBEEF);
    chk("rwfull_count", W'(bus.F_Count), 32'd16);
    chk("rwfull_head",  bus.F_Data,      32'h201);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("beef_last", bus.F_Data, 32'hBEEF);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("ovf_sticky", W'(bus.F_OvfN), 32'd0);

    // Underflow on empty, then write+read on empty
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("udf_flag",  W'(bus.F_UdfN),  32'd0);
    chk("udf_count", W'(bus.F_Count), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h55);
    chk("rwempty_count", W'(bus.F_Count), 32'd1);
    chk("rwempty_data",  bus.F_Data,      32'h55);

    // Almost-full / almost-empty thresholds
    bus.AFullThr  = 5'd12;
    bus.AEmptyThr = 5'd3;
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300 + 32'(i));
      if (i == 2)  chk("ae_at3",  W'(bus.F_AEmptyN), 32'd0);
      if (i == 3)  chk("ae_at4",  W'(bus.F_AEmptyN), 32'd1);
      if (i == 10) chk("af_at11", W'(bus.F_AFullN),  32'd1);
    end
    chk("af_at12", W'(bus.F_AFullN), 32'd0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) chk("af_back11", W'(bus.F_AFullN),  32'd1);
      if (i == 7) chk("ae_back4",  W'(bus.F_AEmptyN), 32'd1);
    end
    chk("ae_back3", W'(bus.F_AEmptyN), 32'd0);
    bus.AFullThr = 5'd2;
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("af_thrchg", W'(bus.F_AFullN), 32'd0);
    chk("thr_count", W'(bus.F_Count),  32'd3);

    // Wrap-around streaming at constant occupancy
    bus.AFullThr  = 5'd14;
    bus.AEmptyThr = 5'd2;
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h400 + 32'(i));
    for (int i = 0; i < 40; i++) begin
      chk("wrap_data", bus.F_Data, 32'h400 + 32'(i));
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h405 + 32'(i));
    end
    chk("wrap_count", W'(bus.F_Count), 32'd5);
    chk("wrap_ovfN",  W'(bus.F_OvfN),  32'd1);
    chk("wrap_udfN",  W'(bus.F_UdfN),  32'd1);

    // Clear, then reset, mid-burst with a concurrent write
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500 + 32'(i));
      if (k == 0) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h777);
      else        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h777);
      chk("flush_count",  W'(bus.F_Count),  32'd0);
      chk("flush_emptyN", W'(bus.F_EmptyN), 32'd0);
      chk("flush_ovfN",   W'(bus.F_OvfN),   32'd1);
      chk("flush_udfN",   W'(bus.F_UdfN),   32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h600 + 32'(k));
      chk("post_count", W'(bus.F_Count), 32'd1);
      chk("post_data",  bus.F_Data,      32'h600 + 32'(k));
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("post_emptyN", W'(bus.F_EmptyN), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
